tour_move_seq: RTL

TOUR_MOVE_SEQ -- requirements
Module: tour_move_seq

---
 rtl/tour_move_seq.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/tour_move_seq.sv
// tour_move_seq
//   Plays back a solved knight's tour by taking over the command path.
//   Each of the 24 one-hot moves becomes two commands. The first is a
//   vertical leg (opcode 0x2). The second is a horizontal leg with
//   fanfare (opcode 0x3). Each command is handed to the command processor
//   and the sequencer waits for its completion before going on.
//
//   Ports
//     clk, rst          clock, synchronous active-high reset
//     start_tour        one-cycle pulse: solver move list is ready
//     move[7:0]         one-hot move read from solver memory at mv_indx
//     mv_indx[4:0]      index of the move being executed (0..23)
//     cmd_UART[15:0]    command from the UART wrapper
//     cmd_rdy_UART      command-valid from the UART wrapper
//     clr_cmd_rdy       command processor has taken the current command
//     send_resp         command processor has finished the current command
//     clr_cmd_rdy_UART  clr_cmd_rdy forwarded to the UART while not usurped
//     cmd[15:0]         command to the command processor
//     cmd_rdy           command-valid to the command processor
//     usurp             high while this block owns the command path
//     resp[7:0]         response byte returned to the remote
//     tour_err          one-cycle pulse on an illegal move or an abort
//
//   Build option
//     TOUR_ABORT_EN  when defined, a UART command arriving mid-tour aborts
//                    the tour and the UART command is consumed.
module tour_move_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_tour,
   input  logic [7:0]  move,
   output logic [4:0]  mv_indx,
   input  logic [15:0] cmd_UART,
   input  logic        cmd_rdy_UART,
   input  logic        clr_cmd_rdy,
   input  logic        send_resp,
   output logic        clr_cmd_rdy_UART,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   output logic        usurp,
   output logic [7:0]  resp,
   output logic        tour_err
);

   localparam logic [4:0] LAST_MOVE = 5'd23;
   localparam logic [7:0] RESP_ACK  = 8'hA5;
   localparam logic [7:0] RESP_BUSY = 8'h5A;

   typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} state_t;

   state_t     state_q, state_d;
   logic [4:0] mv_indx_q, mv_indx_d;
   logic       tour_err_q, tour_err_d;
   logic       move_legal;
   logic       abort_req;

   // Vertical leg. Moves 0,1,2,7 head north and moves 0,1,4,5 cover
   // two squares vertically.
   function automatic logic [15:0] vert_cmd(input logic [7:0] m);
      logic [7:0] heading;
      logic [3:0] count;
      heading = ((m & 8'b1000_0111) != 8'h00) ? 8'h00 : 8'h7F;
      count   = ((m & 8'b0011_0011) != 8'h00) ? 4'd2 : 4'd1;
      return {4'h2, heading, count};
   endfunction

   // Horizontal leg. Moves 0,5,6,7 head east and moves 2,3,6,7 cover
   // two squares horizontally.
   function automatic logic [15:0] horz_cmd(input logic [7:0] m);
      logic [7:0] heading;
      logic [3:0] count;
      heading = ((m & 8'b1110_0001) != 8'h00) ? 8'hBF : 8'h3F;
      count   = ((m & 8'b1100_1100) != 8'h00) ? 4'd2 : 4'd1;
      return {4'h3, heading, count};
   endfunction

   assign move_legal = $onehot(move);

`ifdef TOUR_ABORT_EN
   assign abort_req = (state_q != IDLE) && cmd_rdy_UART;
`else
   assign abort_req = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         mv_indx_q  <= 5'd0;
         tour_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mv_indx_q  <= mv_indx_d;
         tour_err_q <= tour_err_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      mv_indx_d  = mv_indx_q;
      tour_err_d = 1'b0;
      if (abort_req) begin
         state_d    = IDLE;
         tour_err_d = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_tour) begin
                  state_d   = VERT;
                  mv_indx_d = 5'd0;
               end
            end
            VERT: begin
               // The legality check takes priority, so an illegal move
               // never reaches the command processor.
               if (!move_legal) begin
                  state_d    = IDLE;
                  tour_err_d = 1'b1;
               end else if (clr_cmd_rdy) begin
                  state_d = WAIT_V;
               end
            end
            WAIT_V: begin
               if (send_resp) state_d = HORZ;
            end
            HORZ: begin
               if (clr_cmd_rdy) state_d = WAIT_H;
            end
            WAIT_H: begin
               if (send_resp) begin
                  if (mv_indx_q == LAST_MOVE) begin
                     state_d = IDLE;
                  end else begin
                     state_d   = VERT;
                     mv_indx_d = mv_indx_q + 5'd1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Output logic
   always_comb begin
      usurp            = 1'b1;
      cmd              = vert_cmd(move);
      cmd_rdy          = 1'b0;
      clr_cmd_rdy_UART = 1'b0;
      resp             = RESP_BUSY;
      case (state_q)
         IDLE: begin
            usurp            = 1'b0;
            cmd              = cmd_UART;
            cmd_rdy          = cmd_rdy_UART;
            clr_cmd_rdy_UART = clr_cmd_rdy;
            resp             = RESP_ACK;
         end
         VERT: begin
            cmd_rdy = move_legal;
         end
         WAIT_V: begin
            cmd = vert_cmd(move);
         end
         HORZ: begin
            cmd     = horz_cmd(move);
            cmd_rdy = 1'b1;
         end
         WAIT_H: begin
            cmd  = horz_cmd(move);
            resp = (mv_indx_q == LAST_MOVE) ? RESP_ACK : RESP_BUSY;
         end
         default: begin
            usurp = 1'b0;
            resp  = RESP_ACK;
         end
      endcase
      // An abort consumes the pending UART command in the same cycle.
      if (abort_req) clr_cmd_rdy_UART = 1'b1;
   end

   assign mv_indx  = mv_indx_q;
   assign tour_err = tour_err_q;

endmodule
